// File: rtl/axis_uart_core_if.sv
// Byte-wide AXI-Stream channel used for both the UART TX sink and the RX source.
interface axis_uart_core_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_core.sv
// UART transmitter and receiver with AXI-Stream byte ports and a first-word-fall-through RX FIFO.
// Both FSMs share one state encoding; bit timing uses down-counters that reload at terminal count.
//   state     | meaning
//   ST_IDLE   | line idle; TX accepts a byte, RX waits for a falling edge
//   ST_START  | start bit (RX: half-bit wait, then start re-sampled)
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit, only when PARITY != 0
//   ST_STOP   | stop bit(s); RX samples only the first one
module axis_uart_core #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             uart_rx,
  output logic             uart_tx,
  axis_uart_core_if.slave  s_axis,
  axis_uart_core_if.master m_axis,
  output logic             tx_done,
  output logic             rx_done,
  output logic [1:0]       rx_error,
  output logic             rx_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(RX_FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   CNT_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic            ODD       = 1'(PARITY == 2);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------- transmitter
  state_e        tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          tx_par_q;
  logic          tx_q;
  logic          tx_rdy_q;
  logic          tx_done_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (s_axis.tvalid && tx_rdy_q) begin
            tx_state_q <= ST_START;
            tx_rdy_q   <= 1'b0;
            tx_q       <= 1'b0;
            tx_cnt_q   <= CNT_BIT;
            tx_bit_q   <= '0;
            tx_sh_q    <= s_axis.tdata & DATA_MASK;
            tx_par_q   <= (^(s_axis.tdata & DATA_MASK)) ^ ODD;
          end else begin
            tx_rdy_q <= 1'b1;
          end
        end
        default: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end else begin
            tx_cnt_q <= CNT_BIT;
            case (tx_state_q)
              ST_START: begin
                tx_state_q <= ST_DATA;
                tx_q       <= tx_sh_q[0];
              end
              ST_DATA: begin
                if (tx_bit_q == LAST_DATA) begin
                  tx_bit_q <= '0;
                  if (PARITY != 0) begin
                    tx_state_q <= ST_PARITY;
                    tx_q       <= tx_par_q;
                  end else begin
                    tx_state_q <= ST_STOP;
                    tx_q       <= 1'b1;
                  end
                end else begin
                  tx_bit_q <= tx_bit_q + 3'd1;
                  tx_sh_q  <= tx_sh_q >> 1;
                  tx_q     <= tx_sh_q[1];
                end
              end
              ST_PARITY: begin
                tx_state_q <= ST_STOP;
                tx_q       <= 1'b1;
              end
              default: begin
                tx_q <= 1'b1;
                if (tx_bit_q == LAST_STOP) begin
                  tx_state_q <= ST_IDLE;
                  tx_rdy_q   <= 1'b1;
                  tx_done_q  <= 1'b1;
                end else begin
                  tx_bit_q <= tx_bit_q + 3'd1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign uart_tx       = tx_q;
  assign s_axis.tready = tx_rdy_q;
  assign tx_done       = tx_done_q;

  // ---------------------------------------------------------------- receiver
  logic          rx_s1_q;
  logic          rx_s2_q;
  logic          rx_prev_q;
  state_e        rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_perr_q;
  logic          rx_fin_q;
  logic [1:0]    rx_ferr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      rx_fin_q   <= 1'b0;
      rx_ferr_q  <= 2'b00;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_fin_q  <= 1'b0;
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= ST_START;
            rx_cnt_q   <= CNT_HALF;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_perr_q  <= 1'b0;
          end
        end
        default: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else begin
            rx_cnt_q <= CNT_BIT;
            case (rx_state_q)
              ST_START: begin
                rx_state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
              end
              ST_DATA: begin
                rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                if (rx_bit_q == LAST_DATA) begin
                  rx_bit_q   <= '0;
                  rx_state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  rx_bit_q <= rx_bit_q + 3'd1;
                end
              end
              ST_PARITY: begin
                rx_perr_q  <= (^rx_sh_q) ^ rx_s2_q ^ ODD;
                rx_state_q <= ST_STOP;
              end
              default: begin
                // Only the first stop bit is checked; the line is free for a new start at once.
                rx_state_q <= ST_IDLE;
                rx_fin_q   <= 1'b1;
                rx_ferr_q  <= {rx_perr_q, ~rx_s2_q};
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO and status pulses
  logic [7:0]      fifo_mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rx_done_q, rx_done_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic [1:0]      rx_err_q, rx_err_d;
  logic [7:0]      rx_word;
  logic            push, push_ok, pop, full;

  assign rx_word = rx_sh_q >> (8 - DATA_BITS);

  always_comb begin
    push      = rx_fin_q && (rx_ferr_q == 2'b00);
    pop       = (cnt_q != '0) && m_axis.tready;
    full      = (cnt_q == FULL_CNT);
    push_ok   = push && (!full || pop);
    wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d     = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - CNTW'(1);
    end
    rx_done_d = push_ok;
    rx_ovr_d  = push && !push_ok;
    rx_err_d  = rx_fin_q ? rx_ferr_q : 2'b00;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rx_done_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_err_q  <= 2'b00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rx_done_q <= rx_done_d;
      rx_ovr_q  <= rx_ovr_d;
      rx_err_q  <= rx_err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= rx_word;
    end
  end

  assign m_axis.tvalid = (cnt_q != '0);
  assign m_axis.tdata  = (cnt_q != '0) ? fifo_mem_q[rd_ptr_q] : 8'h00;
  assign rx_done       = rx_done_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_error      = rx_err_q;

endmodule

// File: doc/axis_uart_core.md
AXIS_UART_CORE -- requirements
Module: axis_uart_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning aclk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer truncation, must be >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal values 5..8.
REQ-004 SHALL have parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1..2.
REQ-006 SHALL have parameter RX_FIFO_DEPTH, default 16, power of two, 2..64.
REQ-007 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports uart_rx (input, 1, serial in) and uart_tx (output, 1, serial out).
REQ-010 SHALL have ports s_axis_tdata (input, 8), s_axis_tvalid (input, 1), s_axis_tready (output, 1); this is the TX byte sink.
REQ-011 SHALL have ports m_axis_tdata (output, 8), m_axis_tvalid (output, 1), m_axis_tready (input, 1); this is the RX byte source.
REQ-012 SHALL have ports tx_done (output, 1), rx_done (output, 1), rx_error (output, 2: bit0 framing, bit1 parity) and rx_overrun (output, 1); all are single-cycle pulses.

Function -- transmitter
REQ-013 SHALL implement the TX FSM IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE; every state other than IDLE lasts exactly CLKS_PER_BIT cycles per bit.
REQ-014 SHALL drive s_axis_tready = 1 only in IDLE; a byte is accepted when tvalid & tready are both high, and the FSM enters START on the next edge.
REQ-015 SHALL drive uart_tx low for the start bit, then send s_axis_tdata[DATA_BITS-1:0] LSB first; bits above DATA_BITS are ignored.
REQ-016 SHALL send a parity bit that makes the count of ones over data plus parity even (PARITY=1) or odd (PARITY=2).
REQ-017 SHALL drive STOP_BITS high bits, then return to IDLE; tx_done pulses for one cycle on the first IDLE cycle, with tready = 1 in the same cycle.
REQ-018 SHALL hold uart_tx high in IDLE and register it, so it is glitch-free.

Function -- receiver
REQ-019 SHALL pass uart_rx through a two-flop synchroniser, reset value 1; all RX decisions use the synchronised signal.
REQ-020 SHALL implement the RX FSM IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
REQ-021 SHALL leave IDLE on a falling edge of the synchronised line; START re-samples after CLKS_PER_BIT/2 cycles, and a high sample is a false start, returning to IDLE with no flags.
REQ-022 SHALL sample each subsequent bit CLKS_PER_BIT cycles after the previous sample (mid-bit), assembling data LSB first.
REQ-023 SHALL check only the first stop bit; a low stop bit sets framing error (rx_error[0]).
REQ-024 SHALL set parity error (rx_error[1]) on a mismatch in the parity bit; with PARITY=0 this bit is always 0.
REQ-025 SHALL resolve the end of a frame on the cycle after the stop-bit sample:
- any error: rx_error pulses, the frame is discarded, rx_done stays 0;
- otherwise: the word is written to the FIFO zero-extended to 8 bits, and rx_done pulses.
REQ-026 SHALL, after the stop sample, go to IDLE and accept a new falling edge immediately (no stop-bit dwell); the second stop bit is not checked.

Function -- RX FIFO
REQ-027 SHALL be first-word-fall-through: m_axis_tvalid = (count != 0), and m_axis_tdata is the oldest entry.
REQ-028 SHALL pop an entry on m_axis_tvalid & m_axis_tready; tdata is held stable while tvalid=1 and tready=0.
REQ-029 SHALL drop a good frame that arrives when the FIFO is full with no pop in that cycle: rx_overrun pulses and rx_done stays 0.
REQ-030 SHALL accept a push when full if a pop happens in the same cycle; a simultaneous push and pop at any occupancy leaves the count unchanged.
REQ-031 SHALL keep pointers of width log2(RX_FIFO_DEPTH) that wrap naturally, with a count of width log2(RX_FIFO_DEPTH)+1.

Reset
REQ-032 SHALL, on aresetn low, immediately and asynchronously set: both FSMs to IDLE, uart_tx=1, s_axis_tready=0 (1 from the first cycle after release), m_axis_tvalid=0, m_axis_tdata=0, all pulses 0, FIFO empty, counters 0.
REQ-033 SHALL abort any frame in progress when reset is asserted mid-frame; a partial RX frame is never written to the FIFO.

Verification (CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, so CLKS_PER_BIT=16)
REQ-034 TX 8N1 with 0xA5 accepted at cycle T: uart_tx low over T+1..T+16, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high for 16 cycles, tx_done at T+161.
REQ-035 Loopback uart_tx->uart_rx, PARITY=2, bytes 0x00, 0xFF, 0x3C: m_axis delivers the same three bytes in order, 3 rx_done pulses, no rx_error.
REQ-036 RX frame 0x55 with a forced-low stop bit: rx_error=01 pulse, no rx_done, m_axis_tvalid stays 0.
REQ-037 RX_FIFO_DEPTH=4, m_axis_tready=0, 5 good frames: 4 rx_done, 1 rx_overrun; draining yields frames 1-4 only.
REQ-038 uart_rx low pulse of 4 cycles: false start, no flags. Reset asserted mid-TX-data: uart_tx=1 at once, tready=1 one cycle after release.
